demux_1to4_stream: RTL and testbench

Registered 1-to-4 stream demultiplexer, the receive-side counterpart of the 8-bit 4-to-1 mux datapath. Accepts one word per cycle on a valid/ready input and steers it into one of four independently back-pressured output lanes. The lane comes from an explicit select or from an internal round-robin pointer. It sits after the mux/serializer stage and fans a shared stream back out to four consumers.

---
 rtl/demux_pkg.sv | 19 +
 rtl/demux_lane_reg.sv | 42 ++++
 rtl/demux_1to4_stream.sv | 84 ++++++++
 tb/tb_demux_1to4_stream.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_pkg;

  localparam int NUM_LANES  = 4;
  localparam int LANE_IDX_W = 2;
  localparam int COUNT_W    = 16;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // Round-robin successor; the 2-bit index wraps 3 -> 0 on its own.
  function automatic lane_idx_t next_lane(input lane_idx_t cur);
    return lane_idx_t'(cur + 1'b1);
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry valid/ready holding register for a single output lane.
// Latency: word loaded at edge N is presented with out_valid from edge N.
// Backpressure: holds word until out_ready; a same-cycle load overrides the drain.
module demux_lane_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Valid flag: a load always wins, so drain+load in one cycle keeps the lane full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Data register: only a load changes it, so an idle or stalled lane holds its word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= data;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demux steering each word to in_sel or a round-robin lane.
// Latency: word accepted at edge N is visible on its lane from edge N.
// Backpressure: in_ready follows only the target lane (empty or draining this cycle).
module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANE_IDX_W-1:0]      in_sel,
  input  logic                       auto_mode,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]       out_valid,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic [LANE_IDX_W-1:0]      rr_ptr,
  output logic [COUNT_W-1:0]         word_count
);

  lane_idx_t            r_rr_ptr;
  logic [COUNT_W-1:0]   r_word_count;

  lane_idx_t            w_lane;
  logic                 w_in_ready;
  logic                 w_accept;
  logic [NUM_LANES-1:0] w_load;
  logic [NUM_LANES-1:0] w_lane_valid;

  // Target lane and its readiness; a lane draining this cycle can take a new word.
  always_comb begin
    w_lane     = auto_mode ? r_rr_ptr : lane_idx_t'(in_sel);
    w_in_ready = !w_lane_valid[w_lane] || out_ready[w_lane];
    w_accept   = in_valid && w_in_ready;
  end

  // One-hot load strobe into the selected lane register.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_load[k] = w_accept && (w_lane == lane_idx_t'(k));
    end
  end

  // Round-robin pointer moves only on an accepted word in auto mode; otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept && auto_mode) begin
      r_rr_ptr <= next_lane(r_rr_ptr);
    end
  end

  // Accepted-word counter sticks at its maximum; data flow is unaffected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_count <= '0;
    end else if (w_accept && (r_word_count != COUNT_MAX)) begin
      r_word_count <= r_word_count + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_lane_reg #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load[g]),
      .data     (in_data),
      .out_ready(out_ready[g]),
      .out_valid(w_lane_valid[g]),
      .out_data (out_data[g*WIDTH +: WIDTH])
    );
  end

  assign out_valid  = w_lane_valid;
  assign in_ready   = w_in_ready;
  assign rr_ptr     = r_rr_ptr;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Randomised scoreboard bench for demux_1to4_stream.
// Latency: expects lane words visible the cycle after the accepting edge.
// Backpressure: model derives readiness from per-lane pending-word queues.
module tb_demux_1to4_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic        auto_mode;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  demux_1to4_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .auto_mode (auto_mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr),
    .word_count(word_count)
  );

  // Reference model: words still owed by each lane, plus pointer and count.
  logic [7:0] exp_q [4][$];
  logic [1:0] m_rr;
  int         m_cnt;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    m_rr  = 2'd0;
    m_cnt = 0;
  endtask

  // Monitor: compares every visible output against the model on the falling edge
  // and retires a lane's word when the consumer takes it.
  logic [1:0] mon_lane;
  logic       mon_rdy;
  always @(negedge clk) begin
    if (!rst) begin
      mon_lane = auto_mode ? m_rr : in_sel;
      mon_rdy  = (exp_q[mon_lane].size() == 0) || out_ready[mon_lane];
      chk("in_ready", {31'd0, in_ready}, {31'd0, mon_rdy});
      chk("rr_ptr", {30'd0, rr_ptr}, {30'd0, m_rr});
      chk("word_count", {16'd0, word_count}, m_cnt);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]},
            {31'd0, (exp_q[k].size() != 0)});
        if (out_valid[k] && exp_q[k].size() != 0) begin
          chk($sformatf("out_data[%0d]", k), {24'd0, out_data[k*8 +: 8]},
              {24'd0, exp_q[k][0]});
          if (out_ready[k]) void'(exp_q[k].pop_front());
        end
      end
    end
  end

  // One cycle of stimulus, called just after a rising edge. The accept decision is
  // taken from the DUT handshake (checked by the monitor); the model is updated at
  // the accepting edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [1:0] s,
                      input logic am, input logic [3:0] ordy, output logic acc);
    logic [1:0] ln;
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    auto_mode = am;
    out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready;
    ln  = am ? m_rr : s;
    @(posedge clk);
    if (acc) begin
      exp_q[ln].push_back(d);
      if (m_cnt < 65535) m_cnt++;
      if (am) m_rr = m_rr + 2'd1;
    end
    #1;
  endtask

  logic       acc;
  logic       pv;
  logic [7:0] pd;
  logic [1:0] ps;

  initial begin
    rst = 1'b1; in_valid = 0; in_data = 0; in_sel = 0; auto_mode = 0; out_ready = 0;
    model_reset();
    #12;
    chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_rr_ptr", {30'd0, rr_ptr}, 32'd0);
    chk("reset_word_count", {16'd0, word_count}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Auto mode, back-to-back, all consumers ready.
    step(1, 8'hA0, 0, 1, 4'hF, acc); chk("t1_acc0", {31'd0, acc}, 32'd1);
    step(1, 8'hB1, 0, 1, 4'hF, acc); chk("t1_acc1", {31'd0, acc}, 32'd1);
    step(1, 8'hC2, 0, 1, 4'hF, acc); chk("t1_acc2", {31'd0, acc}, 32'd1);
    step(1, 8'hD3, 0, 1, 4'hF, acc); chk("t1_acc3", {31'd0, acc}, 32'd1);
    chk("t1_rr_wrap", {30'd0, rr_ptr}, 32'd0);
    chk("t1_count", {16'd0, word_count}, 32'd4);
    step(0, 8'h00, 0, 1, 4'hF, acc);

    // Manual lane 2 stalled, second word waits, then lands with no bubble.
    step(1, 8'hC2, 2, 0, 4'h0, acc); chk("t2_first", {31'd0, acc}, 32'd1);
    chk("t2_valid", {28'd0, out_valid}, 32'h4);
    step(1, 8'hE4, 2, 0, 4'h0, acc); chk("t2_stalled", {31'd0, acc}, 32'd0);
    step(1, 8'hE4, 2, 0, 4'h4, acc); chk("t2_no_bubble", {31'd0, acc}, 32'd1);
    step(0, 8'h00, 0, 0, 4'hF, acc);

    // Lane 1 stalled while lanes 0 and 3 keep accepting.
    step(1, 8'h55, 1, 0, 4'h0, acc); chk("t3_lane1", {31'd0, acc}, 32'd1);
    step(1, 8'hA0, 0, 0, 4'hD, acc); chk("t3_lane0", {31'd0, acc}, 32'd1);
    step(1, 8'hD3, 3, 0, 4'hD, acc); chk("t3_lane3", {31'd0, acc}, 32'd1);
    chk("t3_lane1_hold", {24'd0, out_data[15:8]}, 32'h55);
    step(0, 8'h00, 0, 0, 4'hF, acc);

    // Auto mode blocked on a full lane, then steered manually to lane 3.
    step(1, 8'h11, 0, 0, 4'h0, acc); chk("t4_fill", {31'd0, acc}, 32'd1);
    step(1, 8'h22, 0, 1, 4'h0, acc); chk("t4_blocked", {31'd0, acc}, 32'd0);
    chk("t4_rr_hold", {30'd0, rr_ptr}, 32'd0);
    step(1, 8'h22, 3, 0, 4'h0, acc); chk("t4_manual", {31'd0, acc}, 32'd1);
    chk("t4_rr_same", {30'd0, rr_ptr}, 32'd0);
    step(0, 8'h00, 0, 0, 4'hF, acc);

    // Asynchronous reset mid-operation with lanes 0 and 2 loaded.
    step(1, 8'h31, 0, 1, 4'h0, acc);
    step(1, 8'h32, 2, 0, 4'h0, acc);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_rr_ptr", {30'd0, rr_ptr}, 32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 8'h00, 0, 0, 4'h0, acc);

    // Randomised traffic; a pending word is held stable until it is accepted.
    pv = 0; acc = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!(pv && !acc)) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = 8'($urandom);
        ps = 2'($urandom);
      end
      step(pv, pd, ps, 1'($urandom_range(0, 1)), 4'($urandom), acc);
    end
    step(0, 8'h00, 0, 0, 4'hF, acc);

    // Counter saturation from a clean reset.
    rst = 1'b1; #1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 65535; i++) step(1, 8'($urandom), 0, 1, 4'hF, acc);
    chk("sat_reach", {16'd0, word_count}, 32'hFFFF);
    step(1, 8'h5A, 0, 1, 4'hF, acc);
    chk("sat_acc", {31'd0, acc}, 32'd1);
    chk("sat_hold", {16'd0, word_count}, 32'hFFFF);
    step(0, 8'h00, 0, 0, 4'hF, acc);
    step(0, 8'h00, 0, 0, 4'hF, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
